// File: rtl/nn_result_collector.sv
// Collects recognized digits from the network core into a first-word-fall-through FIFO,
// with sticky error flags and an optional per-digit histogram (enabled by NN_RESULT_HIST_EN).
module nn_result_collector #(
    parameter int DEPTH = 8,
    parameter int OUT_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [OUT_W-1:0]         in_data,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     bad_digit,
    input  logic                     clear,
    input  logic [OUT_W-1:0]         hist_idx,
    output logic [CNT_W-1:0]         hist_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             overflow_q, bad_digit_q;

    logic digit_ok, full, pop, push, drop, bad;

    assign digit_ok = 32'(in_data) <= 32'd9;
    assign full     = level_q == LW'(DEPTH);
    assign pop      = (level_q != '0) && out_ready;
    assign push     = in_valid && digit_ok && (!full || pop);
    assign drop     = in_valid && digit_ok && full && !pop;
    assign bad      = in_valid && !digit_ok;

    // Storage carries no reset so it can map onto plain RAM; visibility is gated by level.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            bad_digit_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            overflow_q  <= clear ? 1'b0 : (overflow_q | drop);
            bad_digit_q <= clear ? 1'b0 : (bad_digit_q | bad);
        end
    end

    assign out_valid = level_q != '0;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign bad_digit = bad_digit_q;

`ifdef NN_RESULT_HIST_EN
    logic [10*CNT_W-1:0] hist_flat;
    logic [CNT_W-1:0]    hist_sel;
    logic [CNT_W-1:0]    hist_cnt_q;

    // Dropped-on-full digits still count: the histogram tracks classifications, not storage.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_hist
            logic [CNT_W-1:0] cnt_q;
            logic             hit;

            assign hit = in_valid && (32'(in_data) == gi);

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    cnt_q <= '0;
                end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign hist_flat[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate

    always_comb begin
        hist_sel = '0;
        for (int i = 0; i < 10; i++) begin
            if (32'(hist_idx) == i) begin
                hist_sel = hist_flat[i*CNT_W +: CNT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_cnt_q <= '0;
        end else begin
            hist_cnt_q <= hist_sel;
        end
    end

    assign hist_cnt = hist_cnt_q;
`else
    logic unused_hist_idx;
    assign unused_hist_idx = ^hist_idx;
    assign hist_cnt        = '0;
`endif

endmodule

// File: tb/tb_nn_result_collector.sv
// Directed bench for nn_result_collector: a vector table for the FIFO/flag behaviour plus
// hand sequences for overflow, full push+pop, clear priority, saturation and mid-stream reset.
module tb_nn_result_collector;
    localparam int DEPTH = 8;
    localparam int OUT_W = 4;
    localparam int CNT_W = 4;
`ifdef NN_RESULT_HIST_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [OUT_W-1:0] in_data;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_ready;
    logic [3:0]       level;
    logic             overflow;
    logic             bad_digit;
    logic             clear;
    logic [OUT_W-1:0] hist_idx;
    logic [CNT_W-1:0] hist_cnt;

    int n_total = 0;
    int n_pass  = 0;

    nn_result_collector #(.DEPTH(DEPTH), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .bad_digit (bad_digit),
        .clear     (clear),
        .hist_idx  (hist_idx),
        .hist_cnt  (hist_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       r;
        logic       clr;
        int         lvl;
        logic       ov;
        logic [3:0] od;
        logic       of;
        logic       bd;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Drive inputs, let one rising edge pass, then sample 1 time unit later.
    task automatic step(input logic v, input logic [3:0] d, input logic r, input logic c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        @(posedge clk);
        #1;
        $display("t=%0t rst=%0b v=%0b d=%0d rdy=%0b clr=%0b -> lvl=%0d ov=%0b od=%0d of=%0b bd=%0b hc=%0d",
                 $time, rst, v, d, r, c, level, out_valid, out_data, overflow, bad_digit, hist_cnt);
    endtask

    task automatic hist_rd(input int idx, input int exp_cnt, input string nm);
        hist_idx = 4'(idx);
        step(1'b0, 4'd0, 1'b0, 1'b0);
        chk(nm, int'(hist_cnt), HIST ? exp_cnt : 0);
    endtask

    task automatic chk_state(input string nm, input int lvl, input int ov, input int od,
                             input int of, input int bd);
        chk({nm, " level"},     int'(level),     lvl);
        chk({nm, " out_valid"}, int'(out_valid), ov);
        chk({nm, " out_data"},  int'(out_data),  od);
        chk({nm, " overflow"},  int'(overflow),  of);
        chk({nm, " bad_digit"}, int'(bad_digit), bd);
    endtask

    initial begin
        int exp_drain[8];
        exp_drain = '{1, 2, 3, 4, 5, 6, 7, 5};

        //        v  d   r  clr  lvl ov od of bd
        tbl[0]  = '{1, 3,  0, 0,  1, 1, 3, 0, 0};
        tbl[1]  = '{1, 7,  0, 0,  2, 1, 3, 0, 0};
        tbl[2]  = '{1, 1,  0, 0,  3, 1, 3, 0, 0};
        tbl[3]  = '{0, 0,  0, 0,  3, 1, 3, 0, 0};
        tbl[4]  = '{0, 0,  1, 0,  2, 1, 7, 0, 0};
        tbl[5]  = '{0, 0,  1, 0,  1, 1, 1, 0, 0};
        tbl[6]  = '{0, 0,  1, 0,  0, 0, 0, 0, 0};
        tbl[7]  = '{1, 12, 0, 0,  0, 0, 0, 0, 1};
        tbl[8]  = '{0, 0,  0, 1,  0, 0, 0, 0, 0};
        tbl[9]  = '{1, 12, 0, 1,  0, 0, 0, 0, 0};
        tbl[10] = '{1, 5,  1, 0,  1, 1, 5, 0, 0};
        tbl[11] = '{1, 6,  1, 0,  1, 1, 6, 0, 0};
        tbl[12] = '{0, 0,  1, 0,  0, 0, 0, 0, 0};

        rst      = 1'b1;
        hist_idx = 4'd0;
        step(1'b1, 4'd4, 1'b0, 1'b0);
        step(1'b1, 4'd4, 1'b0, 1'b0);
        chk_state("reset", 0, 0, 0, 0, 0);
        chk("reset hist_cnt", int'(hist_cnt), 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].clr);
            chk_state($sformatf("row%0d", i), tbl[i].lvl, int'(tbl[i].ov), int'(tbl[i].od),
                      int'(tbl[i].of), int'(tbl[i].bd));
        end
        hist_rd(5, 1, "tbl hist5");
        hist_rd(6, 1, "tbl hist6");
        hist_rd(3, 0, "tbl hist3 cleared");

        // Fill past capacity: ninth digit dropped but still counted.
        rst = 1'b1;
        step(1'b0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 4'(k), 1'b0, 1'b0);
            if (k == 7) chk_state("fill8", 8, 1, 0, 0, 0);
        end
        chk_state("fill9", 8, 1, 0, 1, 0);
        hist_rd(8, 1, "ovf hist8");
        hist_rd(0, 1, "ovf hist0");
        hist_rd(9, 0, "ovf hist9");

        step(1'b1, 4'd5, 1'b1, 1'b0);
        chk_state("full push+pop", 8, 1, 1, 1, 0);
        step(1'b1, 4'd4, 1'b0, 1'b1);
        chk_state("clear on drop", 8, 1, 1, 0, 0);
        hist_rd(4, 0, "clear beats inc");
        hist_rd(5, 0, "clear hist5");

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d data", i), int'(out_data), exp_drain[i]);
            step(1'b0, 4'd0, 1'b1, 1'b0);
        end
        chk_state("drained", 0, 0, 0, 0, 0);

        // Saturation, then reset while data and flags are live.
        rst = 1'b1;
        step(1'b0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) step(1'b1, 4'd2, 1'b1, 1'b0);
        chk_state("stream2", 1, 1, 2, 0, 0);
        hist_rd(2, 15, "sat hist2");
        hist_rd(12, 0, "idx12");
        step(1'b1, 4'd12, 1'b0, 1'b0);
        chk_state("pre-rst", 1, 1, 2, 0, 1);
        hist_idx = 4'd2;
        rst = 1'b1;
        step(1'b1, 4'd3, 1'b1, 1'b0);
        chk_state("midrst", 0, 0, 0, 0, 0);
        chk("midrst hist_cnt", int'(hist_cnt), 0);
        rst = 1'b0;
        hist_rd(2, 0, "post-rst hist2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/nn_result_collector.md
NN_RESULT_COLLECTOR -- requirements
Module: nn_result_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter OUT_W, default 4, digit code width.
REQ-003 SHALL have parameter CNT_W, default 16, histogram counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  recognized-digit strobe from the network core (net_out_valid).
REQ-007 SHALL have port in_data  input  OUT_W  recognized digit (net_out_data).
REQ-008 SHALL have port out_valid  output  1  FIFO head valid.
REQ-009 SHALL have port out_data  output  OUT_W  FIFO head digit.
REQ-010 SHALL have port out_ready  input  1  downstream accepts head.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port overflow  output  1  sticky: a valid digit was dropped on full.
REQ-013 SHALL have port bad_digit  output  1  sticky: in_data > 9 received.
REQ-014 SHALL have port clear  input  1  clears sticky flags and histogram; FIFO untouched.
REQ-015 SHALL have port hist_idx  input  OUT_W  histogram read index.
REQ-016 SHALL have port hist_cnt  output  CNT_W  count for hist_idx, registered, 1-cycle latency.

Function
REQ-017 SHALL push in_data when in_valid=1, in_data<=9 and FIFO not full (or full with a simultaneous pop).
REQ-018 SHALL never backpressure input (producer has no ready); full with no pop -> drop, set overflow.
REQ-019 SHALL drop in_data>9 without push, set bad_digit, no histogram update.
REQ-020 SHALL present head as first-word-fall-through: out_valid=1 whenever level>0; out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL pop on out_valid & out_ready; push and pop same cycle leave level unchanged.
REQ-022 SHALL make a pushed digit visible at out_valid the cycle after the push (1-cycle latency into empty FIFO).
REQ-023 SHALL wrap read/write pointers modulo DEPTH; level range 0..DEPTH.
REQ-024 SHALL increment hist[in_data] for every accepted digit AND every overflow-dropped valid digit (counts classifications, not storage).
REQ-025 SHALL saturate each histogram counter at 2^CNT_W-1.
REQ-026 SHALL give clear priority over same-cycle histogram increment (counter becomes 0) and over same-cycle flag set (flag becomes 0).
REQ-027 SHALL return hist_cnt=0 for hist_idx>9.

Reset
REQ-028 SHALL on rst=1 at a clock edge: level=0, pointers=0, out_valid=0, out_data=0, overflow=0, bad_digit=0, all counters=0, hist_cnt=0.
REQ-029 SHALL discard FIFO contents when rst asserts mid-operation; inputs ignored while rst=1.

Configuration
REQ-030 SHALL compile histogram logic only when macro NN_RESULT_HIST_EN is defined.
REQ-031 SHALL, without NN_RESULT_HIST_EN, keep hist_idx/hist_cnt ports, drive hist_cnt=0 constantly, and ignore clear for histogram (clear still clears flags).

Verification
REQ-032 Push digits 3,7,1 with out_ready=0 -> level=3, out_valid=1, out_data=3; then out_ready=1 -> outputs 3,7,1 on consecutive cycles, level=0.
REQ-033 Push 9 valid digits (DEPTH=8), out_ready=0 -> level=8, 9th dropped, overflow=1, hist counts include all 9.
REQ-034 Full FIFO, simultaneous in_valid(5) and pop -> level stays 8, 5 stored at tail, overflow unchanged.
REQ-035 in_data=12 pulse -> bad_digit=1, level unchanged, all hist unchanged; clear -> bad_digit=0.
REQ-036 With CNT_W=4, push digit 2 twenty times (draining) -> hist_idx=2 reads 15 one cycle later; rst mid-stream -> all outputs per REQ-028 next cycle.
